// File: rtl/uart_decoder_if.sv
// uart_decoder_if
//   Groups the serial-line, configuration and result signals of uart_decoder.
//   Signals:
//     data_in      serial receive line, idles high
//     baudcontrol  clocks per bit (N)
//     parity       1 = frame carries an even-parity bit
//     done         level: a frame has been received
//     data_out     {22'b0, framing err, parity err, byte}
//   Modports:
//     master  drives the line and configuration, observes results
//     slave   the decoder side
interface uart_decoder_if;
    logic        data_in;
    logic [23:0] baudcontrol;
    logic        parity;
    logic        done;
    logic [31:0] data_out;

    modport master (
        output data_in,
        output baudcontrol,
        output parity,
        input  done,
        input  data_out
    );

    modport slave (
        input  data_in,
        input  baudcontrol,
        input  parity,
        output done,
        output data_out
    );
endinterface

// File: rtl/uart_decoder.sv
// uart_decoder
//   Oversampling UART receiver: 1 start bit, 8 data bits LSB first, optional
//   even-parity bit, 1 stop bit. Bit period is N = baudcontrol clocks, latched
//   together with the parity flag at each start-bit falling edge.
//   Ports:
//     clk   system clock, rising edge
//     nrst  asynchronous active-low reset
//     bus   uart_decoder_if.slave (data_in, baudcontrol, parity, done, data_out)
//   Configuration:
//     UART_DECODER_PARITY_EN  defined: parity input and PAR state active.
//                             undefined: parity ignored, data_out[8] = 0.
module uart_decoder (
    input  logic          clk,
    input  logic          nrst,
    uart_decoder_if.slave bus
);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_sync1;
    logic        r_sync2;
    logic        r_prev;
    logic [23:0] r_n;
    logic [23:0] r_baud_cnt;
    logic [3:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_ferr;
    logic        r_complete;
    logic        r_done;
    logic [7:0]  r_byte_out;
    logic        r_ferr_out;

    logic        w_fall;
    logic        w_enable;
    logic [23:0] w_target;
    logic        w_tick;
    logic        w_frame_start;
    logic        w_start_ok;
    logic        w_data_shift;
    logic        w_last_bit;
    logic        w_par_sample;
    logic        w_stop_sample;
    logic        w_par_en;
    logic        w_perr_out;

`ifdef UART_DECODER_PARITY_EN
    logic        r_par_en;
    logic        r_perr;
    logic        r_perr_out;

    assign w_par_en   = r_par_en;
    assign w_perr_out = r_perr_out;
`else
    logic        w_unused_parity;

    assign w_unused_parity = bus.parity;
    assign w_par_en        = 1'b0;
    assign w_perr_out      = 1'b0;
`endif

    assign w_fall   = r_prev & ~r_sync2;
    assign w_enable = (bus.baudcontrol >= 24'd2);

    // START waits half a bit to land in the middle of the start bit;
    // every later state waits a full bit.
    always_comb begin
        w_target = r_n - 24'd1;
        if (r_state == START) begin
            w_target = {1'b0, r_n[23:1]} - 24'd1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (w_frame_start) w_next = START;
            START: if (w_tick)        w_next = r_sync2 ? IDLE : DATA;
            DATA:  if (w_last_bit)    w_next = w_par_en ? PAR : STOP;
            PAR:   if (w_par_sample)  w_next = STOP;
            STOP:  if (w_stop_sample) w_next = IDLE;
            default:                  w_next = IDLE;
        endcase
    end

    // FSM output strobes
    always_comb begin
        w_tick        = (r_state != IDLE) && (r_baud_cnt == w_target);
        w_frame_start = (r_state == IDLE) && w_fall && w_enable;
        w_start_ok    = (r_state == START) && w_tick && !r_sync2;
        w_data_shift  = (r_state == DATA) && w_tick;
        w_last_bit    = w_data_shift && (r_bit_cnt == 4'd7);
        w_par_sample  = (r_state == PAR) && w_tick;
        w_stop_sample = (r_state == STOP) && w_tick;
    end

    // Synchronizer and edge detector
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= bus.data_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Datapath: counters, shift register, error flags, result registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_n        <= '0;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_ferr     <= 1'b0;
            r_complete <= 1'b0;
            r_done     <= 1'b0;
            r_byte_out <= '0;
            r_ferr_out <= 1'b0;
        end else begin
            r_complete <= w_stop_sample;

            if (w_frame_start) begin
                r_n        <= bus.baudcontrol;
                r_baud_cnt <= '0;
            end else if (r_state != IDLE) begin
                r_baud_cnt <= w_tick ? '0 : r_baud_cnt + 24'd1;
            end

            if (w_start_ok) begin
                r_bit_cnt <= '0;
                r_done    <= 1'b0;
            end else if (w_data_shift) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
                r_shift   <= {r_sync2, r_shift[7:1]};
            end

            if (w_stop_sample) begin
                r_ferr <= ~r_sync2;
            end

            // Result is published one clock after the stop sample.
            if (r_complete) begin
                r_done     <= 1'b1;
                r_byte_out <= r_shift;
                r_ferr_out <= r_ferr;
            end
        end
    end

`ifdef UART_DECODER_PARITY_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_par_en   <= 1'b0;
            r_perr     <= 1'b0;
            r_perr_out <= 1'b0;
        end else begin
            if (w_frame_start) begin
                r_par_en <= bus.parity;
            end
            if (w_start_ok) begin
                r_perr <= 1'b0;
            end else if (w_par_sample) begin
                r_perr <= (^r_shift) ^ r_sync2;
            end
            if (r_complete) begin
                r_perr_out <= r_perr;
            end
        end
    end
`endif

    assign bus.done     = r_done;
    assign bus.data_out = {22'b0, r_ferr_out, w_perr_out, r_byte_out};

endmodule

// File: tb/tb_uart_decoder.sv
module tb_uart_decoder;

    logic clk;
    logic nrst;
    int   total;
    int   bad;

    uart_decoder_if bus ();

    uart_decoder dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send_bit(input logic b, input int n);
        bus.data_in = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input int n, input logic has_par,
                              input logic pbit, input logic sbit);
        send_bit(1'b0, n);
        for (int i = 0; i < 8; i++) send_bit(b[i], n);
        if (has_par) send_bit(pbit, n);
        send_bit(sbit, n);
        if (!sbit) send_bit(1'b1, n);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        nrst            = 1'b0;
        bus.data_in     = 1'b1;
        bus.baudcontrol = 24'd16;
        bus.parity      = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (bus.done !== 1'b0) begin
            bad++; $display("FAIL reset_done got=%b want=0", bus.done);
        end
        total++;
        if (bus.data_out !== 32'h0) begin
            bad++; $display("FAIL reset_data got=%h want=00000000", bus.data_out);
        end
        nrst = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_basic();
        bus.baudcontrol = 24'd16;
        bus.parity      = 1'b0;
        send_frame(8'hA5, 16, 1'b0, 1'b0, 1'b1);
        total++;
        if (bus.done !== 1'b1) begin
            bad++; $display("FAIL basic_done got=%b want=1", bus.done);
        end
        total++;
        if (bus.data_out !== 32'h000000A5) begin
            bad++; $display("FAIL basic_data got=%h want=000000a5", bus.data_out);
        end
    endtask

    task automatic test_parity();
        logic [31:0] exp0;
        logic [31:0] exp1;
`ifdef UART_DECODER_PARITY_EN
        exp0 = 32'h00000003;
        exp1 = 32'h00000103;
`else
        // Without parity support the parity bit is taken as the stop bit.
        exp0 = 32'h00000203;
        exp1 = 32'h00000003;
`endif
        bus.baudcontrol = 24'd16;
        bus.parity      = 1'b1;
        send_frame(8'h03, 16, 1'b1, 1'b0, 1'b1);
        total++;
        if (bus.done !== 1'b1) begin
            bad++; $display("FAIL par0_done got=%b want=1", bus.done);
        end
        total++;
        if (bus.data_out !== exp0) begin
            bad++; $display("FAIL par0_data got=%h want=%h", bus.data_out, exp0);
        end
        send_frame(8'h03, 16, 1'b1, 1'b1, 1'b1);
        total++;
        if (bus.done !== 1'b1) begin
            bad++; $display("FAIL par1_done got=%b want=1", bus.done);
        end
        total++;
        if (bus.data_out !== exp1) begin
            bad++; $display("FAIL par1_data got=%h want=%h", bus.data_out, exp1);
        end
        bus.parity = 1'b0;
    endtask

    task automatic test_framing();
        bus.baudcontrol = 24'd8;
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0);
        total++;
        if (bus.done !== 1'b1) begin
            bad++; $display("FAIL ferr_done got=%b want=1", bus.done);
        end
        total++;
        if (bus.data_out !== 32'h0000025A) begin
            bad++; $display("FAIL ferr_data got=%h want=0000025a", bus.data_out);
        end
    endtask

    task automatic test_glitch();
        bus.baudcontrol = 24'd16;
        bus.data_in     = 1'b0;
        repeat (3) @(negedge clk);
        bus.data_in     = 1'b1;
        repeat (40) @(negedge clk);
        total++;
        if (bus.done !== 1'b1) begin
            bad++; $display("FAIL glitch_done got=%b want=1", bus.done);
        end
        total++;
        if (bus.data_out !== 32'h0000025A) begin
            bad++; $display("FAIL glitch_data got=%h want=0000025a", bus.data_out);
        end
    endtask

    task automatic test_disabled();
        bus.baudcontrol = 24'd1;
        send_frame(8'h00, 16, 1'b0, 1'b0, 1'b1);
        total++;
        if (bus.data_out !== 32'h0000025A) begin
            bad++; $display("FAIL disabled_data got=%h want=0000025a", bus.data_out);
        end
        bus.baudcontrol = 24'd0;
        send_frame(8'h00, 16, 1'b0, 1'b0, 1'b1);
        total++;
        if (bus.data_out !== 32'h0000025A) begin
            bad++; $display("FAIL disabled0_data got=%h want=0000025a", bus.data_out);
        end
        bus.baudcontrol = 24'd16;
    endtask

    task automatic test_midframe_change();
        logic [7:0] b;
        b = 8'h3C;
        bus.baudcontrol = 24'd16;
        bus.parity      = 1'b0;
        send_bit(1'b0, 16);
        bus.baudcontrol = 24'd3;
        bus.parity      = 1'b1;
        for (int i = 0; i < 8; i++) send_bit(b[i], 16);
        send_bit(1'b1, 16);
        repeat (4) @(negedge clk);
        total++;
        if (bus.done !== 1'b1) begin
            bad++; $display("FAIL midchg_done got=%b want=1", bus.done);
        end
        total++;
        if (bus.data_out !== 32'h0000003C) begin
            bad++; $display("FAIL midchg_data got=%h want=0000003c", bus.data_out);
        end
        bus.baudcontrol = 24'd16;
        bus.parity      = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        b = 8'h22;
        send_frame(8'h11, 16, 1'b0, 1'b0, 1'b1);
        total++;
        if (bus.data_out !== 32'h00000011) begin
            bad++; $display("FAIL b2b_first got=%h want=00000011", bus.data_out);
        end
        bus.data_in = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (bus.done !== 1'b1) begin
            bad++; $display("FAIL b2b_done_before_check got=%b want=1", bus.done);
        end
        repeat (12) @(negedge clk);
        total++;
        if (bus.done !== 1'b0) begin
            bad++; $display("FAIL b2b_done_after_check got=%b want=0", bus.done);
        end
        total++;
        if (bus.data_out !== 32'h00000011) begin
            bad++; $display("FAIL b2b_hold got=%h want=00000011", bus.data_out);
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) send_bit(b[i], 16);
        send_bit(1'b1, 16);
        repeat (4) @(negedge clk);
        total++;
        if (bus.done !== 1'b1) begin
            bad++; $display("FAIL b2b_done got=%b want=1", bus.done);
        end
        total++;
        if (bus.data_out !== 32'h00000022) begin
            bad++; $display("FAIL b2b_data got=%h want=00000022", bus.data_out);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        b = 8'hC3;
        send_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) send_bit(b[i], 16);
        bus.data_in = b[4];
        repeat (8) @(negedge clk);
        nrst = 1'b0;
        #1;
        total++;
        if (bus.done !== 1'b0) begin
            bad++; $display("FAIL rstmid_done got=%b want=0", bus.done);
        end
        total++;
        if (bus.data_out !== 32'h0) begin
            bad++; $display("FAIL rstmid_data got=%h want=00000000", bus.data_out);
        end
        @(negedge clk);
        bus.data_in = 1'b1;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        repeat (20) @(negedge clk);
        total++;
        if (bus.done !== 1'b0) begin
            bad++; $display("FAIL rstmid_idle_done got=%b want=0", bus.done);
        end
        send_frame(8'h7E, 16, 1'b0, 1'b0, 1'b1);
        total++;
        if (bus.done !== 1'b1) begin
            bad++; $display("FAIL rstmid_next_done got=%b want=1", bus.done);
        end
        total++;
        if (bus.data_out !== 32'h0000007E) begin
            bad++; $display("FAIL rstmid_next_data got=%h want=0000007e", bus.data_out);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_parity();
        test_framing();
        test_glitch();
        test_disabled();
        test_midframe_change();
        test_back_to_back();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_decoder.md
UART_DECODER -- requirements
Module: uart_decoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-002 SHALL have port nrst, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port data_in, input, 1 bit: serial receive line; idles high.
REQ-004 SHALL have port baudcontrol, input, 24 bits: clocks per bit, N.
REQ-005 SHALL have port parity, input, 1 bit: 1 = frame carries an even-parity bit.
REQ-006 SHALL have port done, output, 1 bit: a frame has been received; level, not pulse.
REQ-007 SHALL have port data_out, output, 32 bits: [7:0] byte, [8] parity error, [9] framing error, [31:10] zero.

Function
REQ-008 SHALL pass data_in through a 2-flop synchronizer; all sampling below uses the synchronized signal.
REQ-009 SHALL implement states IDLE, START, DATA, PAR, STOP.
REQ-010 SHALL leave IDLE on a synchronized high-to-low transition; the frame then latches baudcontrol and parity.
REQ-011 SHALL stay in IDLE while baudcontrol < 2; the receiver is disabled.
REQ-012 In START, SHALL wait floor(N/2) clocks, then sample.
REQ-013 SHALL go to DATA if the START sample is low.
REQ-014 SHALL return to IDLE if the START sample is high (glitch), leaving done and data_out unchanged.
REQ-015 In DATA, SHALL take 8 samples spaced N clocks apart, LSB first, into a shift register.
REQ-016 After DATA, SHALL enter PAR if the latched parity = 1, else STOP.
REQ-017 In PAR, SHALL take one sample N clocks later; parity error = XOR(byte, sample), i.e. even parity.
REQ-018 In STOP, SHALL take one sample N clocks later; framing error = sample is low.
REQ-019 On the clock after the stop sample, SHALL load data_out with {22'b0, ferr, perr, byte}, set done = 1, and return to IDLE.
REQ-020 SHALL still store the byte when an error bit is set.
REQ-021 done SHALL stay 1 until the next valid start bit passes its START check; done then clears in that cycle.
REQ-022 data_out SHALL hold its last value until the next frame completes.
REQ-023 Changes to baudcontrol or parity mid-frame SHALL have no effect until the next frame.
REQ-024 The bit counter and the baud counter SHALL be wide enough for N = 2^24-1 without wrapping.

Reset
REQ-025 While nrst = 0, SHALL force state IDLE, done = 0, data_out = 0, counters = 0, and synchronizer flops = 1.
REQ-026 Reset mid-frame SHALL abandon the frame; after release, the decoder waits for a fresh falling edge.

Configuration
REQ-027 Macro UART_DECODER_PARITY_EN defined: the parity input and the PAR state SHALL be implemented as above.
REQ-028 Macro UART_DECODER_PARITY_EN undefined: the parity input SHALL be ignored, PAR SHALL never be entered, and data_out[8] SHALL be constant 0.

Verification
REQ-029 SHALL test: N=16, parity=0, send 0xA5 with stop=1 -> done=1, data_out=0x000000A5.
REQ-030 SHALL test: N=16, parity=1, send 0x03 with parity bit 0 -> data_out=0x00000003; repeat with parity bit 1 -> data_out=0x00000103.
REQ-031 SHALL test: N=8, send 0x5A with stop bit 0 -> done=1, data_out=0x0000025A.
REQ-032 SHALL test: N=16, drive data_in low for 3 clocks then high -> state returns to IDLE, done and data_out unchanged.
REQ-033 SHALL test: frame 0x11 then frame 0x22 -> done drops after the second start check, then rises with data_out=0x00000022.
REQ-034 SHALL test: nrst pulsed low at data bit 4 -> done=0 and data_out=0 immediately; a following 0x7E frame is received correctly.
